// File: rtl/rx_lp_detector_pkg.sv
// Shared D-PHY LP line-state constants and RX low-power FSM state encodings.
package rx_lp_detector_pkg;

    localparam logic [1:0] LP_11 = 2'b11;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_10 = 2'b10;
    localparam logic [1:0] LP_00 = 2'b00;

    typedef enum logic [2:0] {
        RxStop     = 3'd0,
        RxHsRqst   = 3'd1,
        RxHsPrpr   = 3'd2,
        RxHsActive = 3'd3,
        RxErrWait  = 3'd4
    } rx_state_e;

endpackage

// File: rtl/lp_line_sync.sv
// Two-flop synchronizer for the LP line pair, plus an optional glitch filter
// compiled in when RX_LP_GLITCH_FILTER_EN is defined.
module lp_line_sync #(
    parameter int unsigned FILTER_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dp,
    input  logic       dn,
    output logic [1:0] lp
);

    if (FILTER_CYC < 1 || FILTER_CYC > 7) begin : g_bad_filter_cyc
        $error("FILTER_CYC must be in 1..7");
    end

    logic [1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {dp, dn};
            sync2_q <= sync1_q;
        end
    end

`ifdef RX_LP_GLITCH_FILTER_EN
    logic [1:0] lp_q, cand_q;
    logic [2:0] cnt_q, cnt_nxt;

    // A run restarts whenever the synchronized value differs from the one being counted.
    always_comb begin
        cnt_nxt = 3'd1;
        if (sync2_q == cand_q && cnt_q != 3'd0) cnt_nxt = cnt_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_q   <= 2'b11;
            cand_q <= 2'b11;
            cnt_q  <= 3'd0;
        end else if (sync2_q == lp_q) begin
            cnt_q  <= 3'd0;
        end else if (cnt_nxt >= 3'(FILTER_CYC)) begin
            lp_q   <= sync2_q;
            cnt_q  <= 3'd0;
        end else begin
            cand_q <= sync2_q;
            cnt_q  <= cnt_nxt;
        end
    end

    assign lp = lp_q;
`else
    assign lp = sync2_q;
`endif

endmodule

// File: rtl/rx_lp_detector.sv
// D-PHY RX data-lane low-power detector: recognizes LP-11/01/00 HS entry and
// LP-11 burst end. Optional glitch filter via RX_LP_GLITCH_FILTER_EN.
module rx_lp_detector
    import rx_lp_detector_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned FILTER_CYC = 1
) (
    input  logic       RX_BYTE_clk,
    input  logic       RX_rst_n,
    input  logic       Dp,
    input  logic       Dn,
    output logic       RX_TERM_EN,
    output logic       RX_HS_EN,
    output logic       RX_HS_END_DATA,
    output logic       RX_ERR_SOT,
    output logic       RX_STOP_STATE,
    output logic [1:0] RX_LP_STATE
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle_cyc
        $error("SETTLE_CYC must be in 1..15");
    end

    localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

    logic [1:0] lp;
    rx_state_e  state_q;
    logic [3:0] settle_q;
    logic       hs_end_q, err_sot_q;

    lp_line_sync #(
        .FILTER_CYC(FILTER_CYC)
    ) u_sync (
        .clk   (RX_BYTE_clk),
        .rst_n (RX_rst_n),
        .dp    (Dp),
        .dn    (Dn),
        .lp    (lp)
    );

    always_ff @(posedge RX_BYTE_clk or negedge RX_rst_n) begin
        if (!RX_rst_n) begin
            state_q   <= RxStop;
            settle_q  <= 4'd0;
            hs_end_q  <= 1'b0;
            err_sot_q <= 1'b0;
        end else begin
            hs_end_q  <= 1'b0;
            err_sot_q <= 1'b0;
            case (state_q)
                RxStop: begin
                    // Escape mode is unsupported, so LP-10 is as illegal as LP-00.
                    if (lp == LP_01) begin
                        state_q <= RxHsRqst;
                    end else if (lp != LP_11) begin
                        state_q   <= RxErrWait;
                        err_sot_q <= 1'b1;
                    end
                end
                RxHsRqst: begin
                    if (lp == LP_00) begin
                        state_q  <= RxHsPrpr;
                        settle_q <= 4'd0;
                    end else if (lp != LP_01) begin
                        state_q   <= RxErrWait;
                        err_sot_q <= 1'b1;
                    end
                end
                RxHsPrpr: begin
                    if (lp != LP_00) begin
                        state_q   <= RxErrWait;
                        err_sot_q <= 1'b1;
                    end else if (settle_q == SettleLast) begin
                        state_q <= RxHsActive;
                    end else if (settle_q != 4'hf) begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                RxHsActive: begin
                    // HS swing can toggle the LP receivers; only LP-11 ends the burst.
                    if (lp == LP_11) begin
                        state_q  <= RxStop;
                        hs_end_q <= 1'b1;
                    end
                end
                RxErrWait: begin
                    if (lp == LP_11) state_q <= RxStop;
                end
                default: state_q <= RxStop;
            endcase
        end
    end

    assign RX_TERM_EN     = (state_q == RxHsPrpr) || (state_q == RxHsActive);
    assign RX_HS_EN       = (state_q == RxHsActive);
    assign RX_STOP_STATE  = (state_q == RxStop);
    assign RX_HS_END_DATA = hs_end_q;
    assign RX_ERR_SOT     = err_sot_q;
    assign RX_LP_STATE    = lp;

endmodule

// File: tb/tb_rx_lp_detector.sv
// Directed bench for rx_lp_detector; filter scenario built when RX_LP_GLITCH_FILTER_EN is defined.
module tb_rx_lp_detector;

    localparam int unsigned SETTLE = 3;
`ifdef RX_LP_GLITCH_FILTER_EN
    localparam int unsigned FILT = 3;
`else
    localparam int unsigned FILT = 1;
`endif
    // Shortest line dwell that survives the front end.
    localparam int DW = FILT;

    localparam int ETermRise = 0, EHsRise = 1, EEnd = 2, EEndLong = 3, EErr = 4,
                   EErrLong = 5, ETermCyc = 6, EHsCyc = 7, ELpNot11 = 8, EStopLow = 9;
    localparam int NEv = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dp = 1'b1, dn = 1'b1;
    logic       term_en, hs_en, hs_end, err_sot, stop_state;
    logic [1:0] lp_state;

    int n_cmp = 0, n_bad = 0;
    int ev[NEv];
    int base[NEv];
    int cyc = 0, term_rise_at = 0, hs_rise_at = 0, hs_fall_at = 0, end_at = 0;
    logic term_p = 1'b0, hs_p = 1'b0, end_p = 1'b0, err_p = 1'b0;

    always #5 clk = ~clk;

    rx_lp_detector #(
        .SETTLE_CYC(SETTLE),
        .FILTER_CYC(FILT)
    ) dut (
        .RX_BYTE_clk    (clk),
        .RX_rst_n       (rst_n),
        .Dp             (dp),
        .Dn             (dn),
        .RX_TERM_EN     (term_en),
        .RX_HS_EN       (hs_en),
        .RX_HS_END_DATA (hs_end),
        .RX_ERR_SOT     (err_sot),
        .RX_STOP_STATE  (stop_state),
        .RX_LP_STATE    (lp_state)
    );

    initial for (int i = 0; i < NEv; i++) ev[i] = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (term_en && !term_p) begin ev[ETermRise]++; term_rise_at = cyc; end
        if (hs_en && !hs_p) begin ev[EHsRise]++; hs_rise_at = cyc; end
        if (!hs_en && hs_p) hs_fall_at = cyc;
        if (hs_end && !end_p) begin ev[EEnd]++; end_at = cyc; end
        if (hs_end && end_p) ev[EEndLong]++;
        if (err_sot && !err_p) ev[EErr]++;
        if (err_sot && err_p) ev[EErrLong]++;
        if (term_en) ev[ETermCyc]++;
        if (hs_en) ev[EHsCyc]++;
        if (lp_state != 2'b11) ev[ELpNot11]++;
        if (!stop_state) ev[EStopLow]++;
        term_p = term_en;
        hs_p   = hs_en;
        end_p  = hs_end;
        err_p  = err_sot;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < NEv; i++) base[i] = ev[i];
    endtask

    function automatic int delta(input int idx);
        return ev[idx] - base[idx];
    endfunction

    task automatic drive(input logic [1:0] v, input int n);
        {dp, dn} = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_term_en", int'(term_en), 0);
        check("rst_hs_en", int'(hs_en), 0);
        check("rst_hs_end", int'(hs_end), 0);
        check("rst_err_sot", int'(err_sot), 0);
        check("rst_stop_state", int'(stop_state), 1);
        check("rst_lp_state", int'(lp_state), 3);
        rst_n = 1'b1;
        drive(2'b11, 4);
        check("idle_stop_state", int'(stop_state), 1);

        // Nominal entry: LP-01 minimal dwell, LP-00 for 10, back to LP-11.
        snap();
        drive(2'b01, DW);
        drive(2'b00, 10);
        drive(2'b11, 6);
        check("nom_term_rises", delta(ETermRise), 1);
        check("nom_hs_rises", delta(EHsRise), 1);
        check("nom_term_to_hs", hs_rise_at - term_rise_at, SETTLE);
        check("nom_hs_cycles", delta(EHsCyc), 10 - SETTLE);
        check("nom_end_pulses", delta(EEnd), 1);
        check("nom_end_long", delta(EEndLong), 0);
        check("nom_end_vs_hs_fall", end_at - hs_fall_at, 0);
        check("nom_err_pulses", delta(EErr), 0);
        check("nom_stop_state", int'(stop_state), 1);

        // Aborted request: LP-01 then straight back to LP-11.
        snap();
        drive(2'b01, DW + 1);
        drive(2'b11, 6);
        check("abort_err_pulses", delta(EErr), 1);
        check("abort_err_long", delta(EErrLong), 0);
        check("abort_term_rises", delta(ETermRise), 0);
        check("abort_stop_state", int'(stop_state), 1);

        // Short prepare: LP-00 too short to reach HS.
        snap();
        drive(2'b01, DW);
        drive(2'b00, DW);
        drive(2'b01, 4);
        check("short_term_rises", delta(ETermRise), 1);
        check("short_term_cycles", delta(ETermCyc), DW);
        check("short_hs_rises", delta(EHsRise), 0);
        check("short_err_pulses", delta(EErr), 1);
        check("short_stop_state", int'(stop_state), 0);
        drive(2'b00, 4);
        check("short_wait_00", int'(stop_state), 0);
        drive(2'b11, 6);
        check("short_back_stop", int'(stop_state), 1);

        // Escape attempt: LP-10 is rejected; only LP-11 recovers.
        snap();
        drive(2'b10, DW);
        drive(2'b00, 5);
        check("esc_err_pulses", delta(EErr), 1);
        check("esc_stop_state", int'(stop_state), 0);
        check("esc_term_rises", delta(ETermRise), 0);
        drive(2'b11, 6);
        check("esc_back_stop", int'(stop_state), 1);

        // Reset in the middle of an HS burst.
        snap();
        drive(2'b01, DW);
        drive(2'b00, 8);
        check("mid_hs_en", int'(hs_en), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_hs_en", int'(hs_en), 0);
        check("arst_term_en", int'(term_en), 0);
        check("arst_stop_state", int'(stop_state), 1);
        check("arst_lp_state", int'(lp_state), 3);
        {dp, dn} = 2'b11;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b11, 4);
        check("arst_no_end", delta(EEnd), 0);
        check("arst_restart_stop", int'(stop_state), 1);

`ifdef RX_LP_GLITCH_FILTER_EN
        // Two-cycle LP-01 glitch is swallowed; a three-cycle dwell is accepted.
        snap();
        drive(2'b01, 2);
        drive(2'b11, 6);
        check("filt_lp_unchanged", delta(ELpNot11), 0);
        check("filt_stop_held", delta(EStopLow), 0);
        snap();
        drive(2'b01, 3);
        drive(2'b00, 10);
        drive(2'b11, 6);
        check("filt_hs_rises", delta(EHsRise), 1);
        check("filt_end_pulses", delta(EEnd), 1);
        check("filt_err_pulses", delta(EErr), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
